serial_subtractor: RTL
======================

# serial_subtractor

Multi-cycle bit-serial subtractor for the architecture elements catalog; the inverse-direction companion to the combinational full adder. It computes `diff = a - b - bin` over `WIDTH` bits, consuming `DIGIT` bits per clock through a ripple of 1-bit full subtractors, and reports borrow-out and signed overflow. It sits in the catalog's arithmetic group, driven by a start/ready handshake and returning a done pulse.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, default 1: bits processed per cycle; 1 ≤ `DIGIT` ≤ `WIDTH`.
- `clk` input 1: the single clock; all state is updated on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request a new operation; it is accepted on a rising edge where `start & ready`.
- `a` input `WIDTH`: minuend; sampled only on accept.
- `b` input `WIDTH`: subtrahend; sampled only on accept.
- `bin` input 1: borrow-in; sampled only on accept.
- `ready` output 1: the block can accept `start`.
- `done` output 1: one-cycle pulse that marks a valid new result.
- `diff` output `WIDTH`: result register.
- `bout` output 1: borrow out of the MSB, i.e. unsigned `a < b + bin`.
- `ovf` output 1: signed two's-complement overflow.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`.
  - `IDLE` → `RUN` on accept.
  - `RUN` → `DONE` after the last digit.
  - `DONE` → `RUN` on accept, else → `IDLE`.
- `ready` = (state == `IDLE`) | (state == `DONE`). A `start` in `RUN` is ignored and is not queued.
- On accept:
  - Load operand shift registers with `a` and `b`.
  - Load the borrow flop with `bin`.
  - Clear the working result register.
  - Clear the digit counter.
- Each `RUN` cycle:
  - The low `DIGIT` bits of the operand registers go through a `DIGIT`-long chain of `full_subtractor`, fed by the borrow flop.
  - The difference digit is shifted into the working result from the MSB side (LSB digit first).
  - The operands shift right by `DIGIT`.
  - The borrow flop takes the chain borrow-out.
  - The counter increments.
- Last digit (counter == `WIDTH/DIGIT - 1`):
  - Copy the completed working result to `diff`.
  - `bout` takes the final borrow.
  - `ovf` = (borrow into MSB bit) XOR (borrow out of MSB bit).
  - State → `DONE`.
- `diff`, `bout` and `ovf` change only on the completing edge. They hold the previous result throughout `RUN` and indefinitely in `IDLE`.
- Arithmetic is modulo 2^`WIDTH`. No saturation.
- Reset values: state `IDLE`, `ready`=1, `done`=0, `diff`=0, `bout`=0, `ovf`=0, counter 0, borrow flop 0.
- Reset mid-operation aborts the operation with no `done` pulse; `diff`, `bout` and `ovf` all return to 0.
- If `rst` and `start` are both high on the same edge, reset wins and the start is dropped.

## Timing
- Let K = `WIDTH/DIGIT`. Accept edge = E0.
- `ready` is low from E0 until E_K.
- The result registers update at E_K. `done`=1 and `ready`=1 in the cycle after E_K; `done` clears at E_{K+1}.
- Latency from accept to `done`: K cycles.
- `DIGIT` = `WIDTH` gives K=1: the result is valid the cycle after accept.
- An accept at E_K+1 (in `DONE`) starts the next operation. `done` still drops at that edge, so sustained throughput is one result per K+1 cycles.
- `done` never stays high for two consecutive cycles.
- The critical path is `DIGIT` ripple stages plus the shift mux.

## Structure
- Shared package `catalog_pkg`:
  - `sub_state_t` enum {`IDLE`, `RUN`, `DONE`}.
  - Localparam helper for K.
  - Counter width = `$clog2(K)` with a minimum of 1.
- Sub-module `full_subtractor`: combinational, ports `x`, `y`, `bi`, `d`, `bo`; d = x^y^bi, bo = (~x&y) | (~(x^y)&bi).
- Instantiate it `DIGIT` times in a generate loop inside `serial_subtractor`.
- `WIDTH % DIGIT != 0` is an elaboration-time error.

## Test plan
- `WIDTH`=8, `DIGIT`=1; a=0x05, b=0x03, bin=0 → `done` 8 cycles after accept; `diff`=0x02, `bout`=0, `ovf`=0.
- a=0x03, b=0x05, bin=0 → `diff`=0xFE, `bout`=1, `ovf`=0. Then a=0x80, b=0x01 → `diff`=0x7F, `bout`=0, `ovf`=1.
- a=0x00, b=0x00, bin=1 → `diff`=0xFF, `bout`=1, `ovf`=0. `start` pulsed again during `RUN` is ignored; `ready`=0 throughout `RUN`.
- Assert `rst` at cycle 4 of `RUN` → no `done`; next cycle `ready`=1 and `diff`=0. Then 0x10 - 0x01 → 0x0F after 8 cycles.
- Back-to-back: accept in the `DONE` cycle with a=0x7F, b=0xFF → second `done` exactly 9 cycles after the first; `diff`=0x80, `bout`=1, `ovf`=1.
- `DIGIT`=4: a=0x9C, b=0x2D → `done` 2 cycles after accept; `diff`=0x6F, `bout`=0, `ovf`=1. `DIGIT`=8 gives the same result with latency 1.

Source files
------------

// File: rtl/catalog_pkg.sv
// Shared definitions for the arithmetic group of the architecture elements catalog.
// Holds the serial subtractor state encoding and its sizing helpers.
package catalog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Number of digit steps needed to consume a full operand.
    function automatic int calc_k(input int width, input int digit);
        return width / digit;
    endfunction

    // Digit counter width; never narrower than one bit, even when K is 1.
    function automatic int calc_cnt_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with bo as the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing diff = a - b - bin, DIGIT bits per clock.
// Operands are loaded on a start/ready handshake; a one-cycle done pulse
// marks a new diff/bout/ovf result, which then holds until the next completion.
module serial_subtractor
    import catalog_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int K  = calc_k(WIDTH, DIGIT);
    localparam int CW = calc_cnt_width(K);

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $fatal(1, "serial_subtractor: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    sub_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_next;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   chain_b;
    logic [DIGIT-1:0] digit_d;
    logic             last_digit;

    assign chain_b[0] = borrow;

    for (genvar i = 0; i < DIGIT; i++) begin : g_chain
        full_subtractor u_fs (
            .x  (a_sh[i]),
            .y  (b_sh[i]),
            .bi (chain_b[i]),
            .d  (digit_d[i]),
            .bo (chain_b[i+1])
        );
    end

    // New digits enter at the MSB side so the LSB digit ends up at bit 0.
    if (DIGIT == WIDTH) begin : g_work_full
        assign work_next = digit_d;
    end else begin : g_work_shift
        assign work_next = {digit_d, work[WIDTH-1:DIGIT]};
    end

    assign last_digit = (cnt == CW'(K - 1));
    assign ready      = (state == IDLE) || (state == DONE);

    // Control FSM plus datapath; result registers only move on the completing edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            work   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        borrow <= bin;
                        work   <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    work   <= work_next;
                    borrow <= chain_b[DIGIT];
                    cnt    <= cnt + 1'b1;
                    if (last_digit) begin
                        diff  <= work_next;
                        bout  <= chain_b[DIGIT];
                        ovf   <= chain_b[DIGIT-1] ^ chain_b[DIGIT];
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
